r200_fetchq: RTL and testbench

R200_FETCHQ -- requirements
Module: r200_fetchq

---
 rtl/r200_fetchq.sv | 105 ++++++++++
 tb/tb_r200_fetchq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/r200_fetchq.sv
// Instruction fetch unit: PC sequencing, a single outstanding imem read, and a
// DEPTH-entry FIFO of fetched {pc, instr} pairs with branch/jump redirect flush.
module r200_fetchq #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       br_taken,
    input  logic [XLEN-1:0]            br_targ,
    input  logic                       jmp_taken,
    input  logic [XLEN-1:0]            jmp_targ,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pcp4,
    output logic [$clog2(DEPTH):0]     fq_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] infl_pc;
    logic            inflight;
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            redirect;
    logic [XLEN-1:0] redir_pc;
    logic [CW-1:0]   occ;
    logic            push;
    logic            pop;

    // Branch is older than a jump in the same cycle, so it takes priority.
    assign redirect = br_taken | jmp_taken;
    assign redir_pc = (br_taken ? br_targ : jmp_targ) & ~XLEN'(3);

    // Occupancy includes the outstanding read so a returning word always has a slot.
    assign occ      = count + CW'(inflight);
    assign imem_req = ~rst & ~redirect & (occ < CW'(DEPTH));
    assign imem_addr = pc;

    assign push = inflight & ~redirect;
    assign pop  = out_valid & out_ready & ~redirect;

    assign out_valid = (count != '0);
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];
    assign out_pcp4  = pc_q[rd_ptr] + XLEN'(4);
    assign fq_count  = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            infl_pc  <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect) begin
            pc       <= redir_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                infl_pc <= pc;
                pc      <= pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= infl_pc;
        end
    end

endmodule

// File: tb/tb_r200_fetchq.sv
// Bench for r200_fetchq: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_r200_fetchq;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        br_taken, jmp_taken;
    logic [31:0] br_targ, jmp_targ;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pcp4;
    logic [2:0]  fq_count;

    int checks = 0;
    int errors = 0;
    int nreq   = 0;

    r200_fetchq #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .br_taken(br_taken), .br_targ(br_targ),
        .jmp_taken(jmp_taken), .jmp_targ(jmp_targ), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_pcp4(out_pcp4), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) imem_rdata <= mem(imem_addr);
    always @(posedge clk) if (imem_req) nreq++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of fetched {pc,instr}, the fetch PC and one pending read.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        q[$];
    ent_t        e;
    logic [31:0] mpc;
    logic [31:0] mipc;
    bit          minfl;
    bit          mredir;
    bit          mreq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mpc   = 32'h0;
            mipc  = 32'h0;
            minfl = 1'b0;
        end else begin
            mredir = br_taken | jmp_taken;
            mreq   = !mredir && (q.size() + int'(minfl) < DEPTH);
            if (mredir) begin
                q.delete();
                minfl = 1'b0;
                mpc   = (br_taken ? br_targ : jmp_targ) & ~32'd3;
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (minfl) begin
                    e.pc    = mipc;
                    e.instr = mem(mipc);
                    q.push_back(e);
                end
                minfl = mreq;
                if (mreq) begin
                    mipc = mpc;
                    mpc  = mpc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_imem_req", {31'b0, imem_req},
            {31'b0, !rst && !(br_taken | jmp_taken) && (q.size() + int'(minfl) < DEPTH)});
        chk("m_imem_addr", imem_addr, mpc);
        chk("m_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("m_fq_count", {29'b0, fq_count}, q.size());
        if (q.size() != 0) begin
            chk("m_out_pc", out_pc, q[0].pc);
            chk("m_out_instr", out_instr, q[0].instr);
            chk("m_out_pcp4", out_pcp4, q[0].pc + 32'd4);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        br_taken = 1'b0; jmp_taken = 1'b0; br_targ = '0; jmp_targ = '0;
        tick(2);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_fq_count", {29'b0, fq_count}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Reset release with consumer ready: 2-cycle latency then 1/cycle.
        rst = 1'b0; #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        tick();
        chk("lat_not_yet", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_pc0", out_pc, 32'h0);
        chk("lat_pcp4", out_pcp4, 32'h4);
        chk("lat_instr", out_instr, 32'h1357_9BDF);
        tick(); chk("stream_pc4", out_pc, 32'h4);
        tick(); chk("stream_pc8", out_pc, 32'h8);
        tick(); chk("stream_pcC", out_pc, 32'hC);
        tick(3);

        // Asynchronous reset between edges, then restart at RESET_PC.
        rst = 1'b1; #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_imem_req", {31'b0, imem_req}, 32'd0);
        chk("async_fq_count", {29'b0, fq_count}, 32'd0);
        out_ready = 1'b0;
        tick();
        rst = 1'b0; #1;
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        tick(4);
        chk("pre_br_count", {29'b0, fq_count}, 32'd3);
        chk("pre_br_req", {31'b0, imem_req}, 32'd0);

        // Redirect with 3 queued + one in flight; pop in same cycle ignored.
        br_taken = 1'b1; br_targ = 32'h102; out_ready = 1'b1; #1;
        chk("br_cycle_req", {31'b0, imem_req}, 32'd0);
        tick();
        br_taken = 1'b0; #1;
        chk("br_count", {29'b0, fq_count}, 32'd0);
        chk("br_valid", {31'b0, out_valid}, 32'd0);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_req", {31'b0, imem_req}, 32'd1);
        tick();
        chk("br_no_stale", {31'b0, out_valid}, 32'd0);
        tick();
        chk("br_head_pc", out_pc, 32'h100);
        chk("br_head_instr", out_instr, 32'h1357_9BDF ^ 32'h100);

        // Fill with consumer stalled: exactly four requests.
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0; nreq = 0;
        tick(8);
        chk("fill_nreq", nreq, 32'd4);
        chk("fill_count", {29'b0, fq_count}, 32'd4);
        chk("fill_req", {31'b0, imem_req}, 32'd0);
        chk("fill_addr", imem_addr, 32'h10);
        chk("fill_head", out_pc, 32'h0);

        // Single-cycle ready pulse on a full queue.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; #1;
        chk("pulse_count", {29'b0, fq_count}, 32'd3);
        chk("pulse_head", out_pc, 32'h4);
        chk("pulse_req", {31'b0, imem_req}, 32'd1);
        chk("pulse_addr", imem_addr, 32'h10);
        tick();
        chk("pulse_infl_count", {29'b0, fq_count}, 32'd3);
        chk("pulse_infl_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("refill_count", {29'b0, fq_count}, 32'd4);
        chk("refill_head", out_pc, 32'h4);
        out_ready = 1'b1;
        tick(); chk("drain_8", out_pc, 32'h8);
        tick(); chk("drain_C", out_pc, 32'hC);
        tick(); chk("drain_10", out_pc, 32'h10);
        tick(); chk("drain_14", out_pc, 32'h14);

        // Simultaneous branch and jump: branch wins.
        br_taken = 1'b1; br_targ = 32'h200; jmp_taken = 1'b1; jmp_targ = 32'h300;
        tick();
        br_taken = 1'b0; jmp_taken = 1'b0; #1;
        chk("both_addr", imem_addr, 32'h200);
        chk("both_req", {31'b0, imem_req}, 32'd1);
        tick(2);
        jmp_taken = 1'b1; jmp_targ = 32'h303;
        tick();
        jmp_taken = 1'b0; #1;
        chk("jmp_addr", imem_addr, 32'h300);

        // PC wrap at the top of the address space.
        jmp_taken = 1'b1; jmp_targ = 32'hFFFF_FFFC;
        tick();
        jmp_taken = 1'b0; #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        tick();
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_pcp4", out_pcp4, 32'h0);

        // Mixed traffic: random stalls and occasional redirects, model-checked.
        for (int i = 0; i < 60; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            br_taken  = ($urandom_range(0, 15) == 0);
            jmp_taken = ($urandom_range(0, 15) == 0);
            br_targ   = 32'h400 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            jmp_targ  = 32'h800 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            tick();
        end
        br_taken = 1'b0; jmp_taken = 1'b0; out_ready = 1'b1;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
